// File: rtl/cs_sequencer_pkg.sv
// Purpose: shared types and constants for the chip-select sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cs_sequencer_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // Decoder enable triples, ordered {G1, G2A, G2B}.
    localparam logic [2:0] EN_ON  = 3'b100;
    localparam logic [2:0] EN_OFF = 3'b011;

endpackage

// File: rtl/cs_sequencer_rr_picker.sv
// Purpose: round-robin search of req starting just after last, ascending with wrap.
// Latency: combinational.
// Backpressure: none; any flags a non-empty request vector.
// Ports: req[7:0] request vector, last[2:0] previous winner,
//        pick[2:0] first set bit after last, any = |req.
module rr_picker
    import cs_sequencer_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Offsets 1..8 from last; offset 8 wraps back to last itself, so a sole
    // requester that just finished is still found.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cs_sequencer.sv
// Purpose: round-robin chip-select sequencer driving a 3-to-8 active-low decoder.
// Latency: req sampled at E0 -> SETUP after E0 -> decoder enabled after E1.
// Backpressure: none; grants are bounded to HOLD_MAX enabled cycles, then one disabled cycle.
// Ports: clk, rst (sync, active-high), req[7:0];
//        G1/G2A/G2B decoder enables, C/B/A decoder select (C = MSB),
//        gnt_valid (decoder enabled), gnt_id[2:0] (= {C,B,A}).
module cs_sequencer
    import cs_sequencer_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             G1,
    output logic             G2A,
    output logic             G2B,
    output logic             C,
    output logic             B,
    output logic             A,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_id
);

    localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] id, id_nxt;
    logic [SEL_W-1:0] last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] pick;
    logic             any;

    rr_picker u_picker (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            id    <= '0;
            last  <= SEL_W'(N_REQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (any) begin
                    id_nxt    = pick;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                // A requester that vanished before enable is dropped without
                // advancing the round-robin pointer.
                if (req[id]) begin
                    cnt_nxt   = '0;
                    state_nxt = ACTIVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                cnt_nxt = cnt + 1'b1;
                if (!req[id] || cnt == CNT_LAST) begin
                    last_nxt  = id;
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                // last already holds the id just served, so the picker
                // search starts after it.
                if (any) begin
                    id_nxt    = pick;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs: address follows id in every state; the decoder is only
    // enabled in ACTIVE, so the address is stable a full cycle either side.
    assign {G1, G2A, G2B} = (state == ACTIVE) ? EN_ON : EN_OFF;
    assign {C, B, A}      = id;
    assign gnt_id         = id;
    assign gnt_valid      = (state == ACTIVE);

endmodule
